// File: rtl/decoder_pkg.sv
// Shared defaults and reference decode function for the one-hot write-enable decoder.
// With ZERO_REG_MASK_EN defined, address 0 decodes to all-zero (hardwired $r0).
package decoder_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned OUT_W_DEF  = 1 << ADDR_W_DEF;

  function automatic logic [OUT_W_DEF-1:0] onehot_f(input logic [ADDR_W_DEF-1:0] addr,
                                                     input logic                  en);
    logic [OUT_W_DEF-1:0] v;
    v = '0;
    if (en) v[addr] = 1'b1;
`ifdef ZERO_REG_MASK_EN
    if (addr == '0) v = '0;
`endif
    return v;
  endfunction

endpackage

// File: rtl/decoder_onehot_comb.sv
// Combinational N-to-2^N one-hot decode with enable.
// With ZERO_REG_MASK_EN defined, bit 0 is tied low.
module decoder_onehot_comb
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    en,
  output logic [(1<<ADDR_W)-1:0]  onehot
);

  for (genvar i = 0; i < (1 << ADDR_W); i++) begin : g_bit
`ifdef ZERO_REG_MASK_EN
    if (i == 0) begin : g_zero
      assign onehot[i] = 1'b0;
    end else begin : g_dec
      assign onehot[i] = en && (addr == ADDR_W'(i));
    end
`else
    assign onehot[i] = en && (addr == ADDR_W'(i));
`endif
  end

endmodule

// File: rtl/decoder_onehot_pipe.sv
// Registered one-hot write-enable decoder with valid/ready and a 2-entry (output + skid) buffer.
// Optional ZERO_REG_MASK_EN masks address 0 to an all-zero one-hot.
module decoder_onehot_pipe
  import decoder_pkg::*;
#(
  parameter  int unsigned ADDR_W = ADDR_W_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned OUT_W  = 1 << ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_en,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_onehot,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_onehot_q, out_onehot_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic              skid_en_q, skid_en_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              accept, load_out;
  logic [ADDR_W-1:0] mux_addr;
  logic              mux_en;
  logic [DATA_W-1:0] mux_data;
  logic [OUT_W-1:0]  dec_onehot;

  // Ready depends only on skid state and reset, never on out_ready.
  assign in_ready = !skid_valid_q && !reset;
  assign accept   = in_valid && in_ready;
  assign load_out = !out_valid_q || out_ready;

  // Skid entry is older than any input, so it always wins the mux.
  assign mux_addr = skid_valid_q ? skid_addr_q : in_addr;
  assign mux_en   = skid_valid_q ? skid_en_q   : in_en;
  assign mux_data = skid_valid_q ? skid_data_q : in_data;

  decoder_onehot_comb #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr   (mux_addr),
    .en     (mux_en),
    .onehot (dec_onehot)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_onehot_d = out_onehot_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_en_d    = skid_en_q;
    skid_data_d  = skid_data_q;
    if (load_out) begin
      out_valid_d  = skid_valid_q || accept;
      skid_valid_d = 1'b0;
      if (skid_valid_q || accept) begin
        out_onehot_d = dec_onehot;
        out_addr_d   = mux_addr;
        out_data_d   = mux_data;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_addr_d  = in_addr;
      skid_en_d    = in_en;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_en_q    <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_en_q    <= skid_en_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Self-checking bench for decoder_onehot_pipe: directed vectors on a default-width instance,
// plus random valid/ready scoreboarding on ADDR_W=3 and ADDR_W=6 instances.
module tb_decoder_onehot_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Default-width instance for directed vectors
  logic        in_valid, in_ready, in_en, out_valid, out_ready;
  logic [4:0]  in_addr, out_addr;
  logic [31:0] in_data, out_data, out_onehot;

  decoder_onehot_pipe dut (
    .clock (clock), .reset (reset),
    .in_valid (in_valid), .in_ready (in_ready), .in_addr (in_addr), .in_en (in_en),
    .in_data (in_data), .out_valid (out_valid), .out_ready (out_ready),
    .out_onehot (out_onehot), .out_addr (out_addr), .out_data (out_data)
  );

  logic        iv3, ir3, en3, ov3, or3;
  logic [2:0]  ia3, oa3;
  logic [15:0] id3, od3;
  logic [7:0]  oh3;

  decoder_onehot_pipe #(.ADDR_W(3), .DATA_W(16)) dut3 (
    .clock (clock), .reset (reset),
    .in_valid (iv3), .in_ready (ir3), .in_addr (ia3), .in_en (en3), .in_data (id3),
    .out_valid (ov3), .out_ready (or3), .out_onehot (oh3), .out_addr (oa3), .out_data (od3)
  );

  logic        iv6, ir6, en6, ov6, or6;
  logic [5:0]  ia6, oa6;
  logic [15:0] id6, od6;
  logic [63:0] oh6;

  decoder_onehot_pipe #(.ADDR_W(6), .DATA_W(16)) dut6 (
    .clock (clock), .reset (reset),
    .in_valid (iv6), .in_ready (ir6), .in_addr (ia6), .in_en (en6), .in_data (id6),
    .out_valid (ov6), .out_ready (or6), .out_onehot (oh6), .out_addr (oa6), .out_data (od6)
  );

  typedef struct {
    logic [5:0]  addr;
    logic        en;
    logic [15:0] data;
  } item_t;

  item_t q3[$];
  item_t q6[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_oh(input logic [5:0] a, input logic en);
    if (!en) return 64'h0;
`ifdef ZERO_REG_MASK_EN
    if (a == 6'd0) return 64'h0;
`endif
    return 64'h1 << a;
  endfunction

  task automatic hs3();
    item_t it;
    if (ov3 && or3) begin
      if (q3.size() == 0) check("r3 spurious", 1, 0);
      else begin
        it = q3.pop_front();
        check("r3 addr", 64'(oa3), 64'(it.addr));
        check("r3 data", 64'(od3), 64'(it.data));
        check("r3 onehot", 64'(oh3), exp_oh(it.addr, it.en));
      end
    end
    if (iv3 && ir3) begin
      it.addr = {3'b0, ia3}; it.en = en3; it.data = id3;
      q3.push_back(it);
    end
  endtask

  task automatic hs6();
    item_t it;
    if (ov6 && or6) begin
      if (q6.size() == 0) check("r6 spurious", 1, 0);
      else begin
        it = q6.pop_front();
        check("r6 addr", 64'(oa6), 64'(it.addr));
        check("r6 data", 64'(od6), 64'(it.data));
        check("r6 onehot", oh6, exp_oh(it.addr, it.en));
      end
    end
    if (iv6 && ir6) begin
      it.addr = ia6; it.en = en6; it.data = id6;
      q6.push_back(it);
    end
  endtask

  task automatic send(input logic [4:0] a, input logic e, input logic [31:0] d);
    in_valid = 1'b1; in_addr = a; in_en = e; in_data = d;
  endtask

  logic [31:0] exp32;

  initial begin
    in_valid = 0; in_addr = 0; in_en = 0; in_data = 0; out_ready = 0;
    iv3 = 0; ia3 = 0; en3 = 0; id3 = 0; or3 = 0;
    iv6 = 0; ia6 = 0; en6 = 0; id6 = 0; or6 = 0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst out_valid", 64'(out_valid), 0);
    check("rst in_ready", 64'(in_ready), 0);
    check("rst onehot", 64'(out_onehot), 0);
    check("rst addr", 64'(out_addr), 0);
    check("rst data", 64'(out_data), 0);
    reset = 1'b0;
    #1 check("rel in_ready", 64'(in_ready), 1);

    // Back-to-back decode, 32 results in 32 cycles
    out_ready = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      @(negedge clock);
      if (i > 0) begin
        exp32 = 32'h1 << (i - 1);
`ifdef ZERO_REG_MASK_EN
        if (i == 1) exp32 = 32'h0;
`endif
        check("b2b valid", 64'(out_valid), 1);
        check("b2b onehot", 64'(out_onehot), 64'(exp32));
        check("b2b addr", 64'(out_addr), 64'(i - 1));
      end
      if (i < 32) send(5'(i), 1'b1, 32'(i));
      else in_valid = 1'b0;
    end
    @(negedge clock);
    check("b2b drained", 64'(out_valid), 0);

    // Stall with skid
    out_ready = 1'b0;
    send(5'd3, 1'b1, 32'h33);
    @(negedge clock);
    check("stall ready1", 64'(in_ready), 1);
    check("stall oh1", 64'(out_onehot), 64'h8);
    send(5'd7, 1'b1, 32'h77);
    @(negedge clock);
    check("stall ready2", 64'(in_ready), 0);
    send(5'd15, 1'b1, 32'hFF); // ignored while full
    repeat (2) @(negedge clock);
    check("stall hold oh", 64'(out_onehot), 64'h8);
    check("stall hold data", 64'(out_data), 64'h33);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("unstall valid", 64'(out_valid), 1);
    check("unstall oh", 64'(out_onehot), 64'h80);
    check("unstall data", 64'(out_data), 64'h77);
    check("unstall ready", 64'(in_ready), 1);
    @(negedge clock);
    check("unstall empty", 64'(out_valid), 0);

    // en=0 passes payload with zero one-hot
    send(5'd9, 1'b0, 32'hDEADBEEF);
    @(negedge clock);
    in_valid = 1'b0;
    check("en0 valid", 64'(out_valid), 1);
    check("en0 onehot", 64'(out_onehot), 0);
    check("en0 addr", 64'(out_addr), 9);
    check("en0 data", 64'(out_data), 64'hDEADBEEF);

    // Zero register
    send(5'd0, 1'b1, 32'h5);
    @(negedge clock);
    in_valid = 1'b0;
    check("r0 valid", 64'(out_valid), 1);
`ifdef ZERO_REG_MASK_EN
    check("r0 onehot", 64'(out_onehot), 0);
`else
    check("r0 onehot", 64'(out_onehot), 1);
`endif
    @(negedge clock);

    // Reset mid-stream with both entries full
    out_ready = 1'b0;
    send(5'd1, 1'b1, 32'h1);
    @(negedge clock);
    send(5'd2, 1'b1, 32'h2);
    @(negedge clock);
    check("mid full ready", 64'(in_ready), 0);
    check("mid full valid", 64'(out_valid), 1);
    reset = 1'b1; in_valid = 1'b0;
    #1 check("mid async valid", 64'(out_valid), 0);
    @(negedge clock);
    check("mid rst valid", 64'(out_valid), 0);
    check("mid rst ready", 64'(in_ready), 0);
    check("mid rst onehot", 64'(out_onehot), 0);
    reset = 1'b0;
    #1 check("mid rel ready", 64'(in_ready), 1);
    @(negedge clock);
    check("mid no partial", 64'(out_valid), 0);

    // Random valid/ready on the narrow and wide instances
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock);
      iv3 = ($urandom_range(0, 3) != 0); ia3 = 3'($urandom); en3 = ($urandom_range(0, 7) != 0);
      id3 = 16'($urandom); or3 = ($urandom_range(0, 2) != 0);
      iv6 = ($urandom_range(0, 2) != 0); ia6 = 6'($urandom); en6 = ($urandom_range(0, 7) != 0);
      id6 = 16'($urandom); or6 = ($urandom_range(0, 3) != 0);
      hs3();
      hs6();
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      iv3 = 1'b0; or3 = 1'b1; iv6 = 1'b0; or6 = 1'b1;
      hs3();
      hs6();
    end
    check("r3 lost", 64'(q3.size()), 0);
    check("r6 lost", 64'(q6.size()), 0);
    check("r3 idle", 64'(ov3), 0);
    check("r6 idle", 64'(ov6), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
